// File: rtl/rc4_pkg.sv
// Shared types for the RC4 key-search controller: FSM state encoding,
// phase identifiers and the default candidate-key width.
package rc4_pkg;

  localparam int KEY_BITS_DEF = 24;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_REL,
    S_INIT,
    S_INIT_REL,
    S_KSA,
    S_KSA_REL,
    S_PRGA,
    S_PRGA_REL,
    S_CHECK,
    S_FOUND,
    S_FAILED
  } state_t;

  typedef enum logic [1:0] {
    PH_LOAD,
    PH_INIT,
    PH_KSA,
    PH_PRGA
  } phase_t;

endpackage

// File: rtl/rc4_search_ctrl_if.sv
// Phase-engine handshake bundle: one level start/finished pair per engine
// plus the PRGA verdict. master = controller side, slave = engine side.
interface rc4_search_ctrl_if;

  logic load_start;
  logic load_finished;
  logic init_start;
  logic init_finished;
  logic ksa_start;
  logic ksa_finished;
  logic prga_start;
  logic prga_finished;
  logic msg_valid;

  modport master (
    output load_start, init_start, ksa_start, prga_start,
    input  load_finished, init_finished, ksa_finished,
    input  prga_finished, msg_valid
  );

  modport slave (
    input  load_start, init_start, ksa_start, prga_start,
    output load_finished, init_finished, ksa_finished,
    output prga_finished, msg_valid
  );

endinterface

// File: rtl/rc4_phase_hs.sv
// Per-phase start/finished/release tracker. go raises start (registered);
// finished drops it; done_pulse marks finished falling after the release.
// Ports: clk, reset, go, finished -> start, done_pulse.
module rc4_phase_hs (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic finished,
  output logic start,
  output logic done_pulse
);

  logic start_q, start_d;
  logic rel_q, rel_d;

  always_comb begin
    start_d = start_q;
    rel_d   = rel_q;
    if (go) begin
      start_d = 1'b1;
    end else if (start_q && finished) begin
      start_d = 1'b0;
      rel_d   = 1'b1;
    end else if (rel_q && !finished) begin
      rel_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      rel_q   <= rel_d;
    end
  end

  // finished is ignored unless this phase is running or releasing
  assign done_pulse = rel_q && !finished;
  assign start      = start_q;

endmodule

// File: rtl/rc4_search_ctrl.sv
// RC4 brute-force sequencer: LOAD once, then INIT/KSA/PRGA per key until
// a valid plaintext or KEY_LAST. Ports: clk, reset, start, eng (engine
// handshakes), secret_key, busy, key_found, key_failed.
// RC4_STATE_TAP_EN adds state_tap and attempts outputs.
module rc4_search_ctrl
  import rc4_pkg::*;
#(
  parameter int                  KEY_BITS  = KEY_BITS_DEF,
  parameter logic [KEY_BITS-1:0] KEY_FIRST = '0,
  parameter logic [KEY_BITS-1:0] KEY_LAST  = '1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  rc4_search_ctrl_if.master   eng,
  output logic [KEY_BITS-1:0] secret_key,
  output logic                busy,
  output logic                key_found,
  output logic                key_failed
`ifdef RC4_STATE_TAP_EN
  ,
  output logic [3:0]          state_tap,
  output logic [KEY_BITS:0]   attempts
`endif
);

  state_t              state_q, state_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic                found_q, found_d;
  logic                failed_q, failed_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [3:0]          go, fin, hs_start, done;
`ifdef RC4_STATE_TAP_EN
  logic [KEY_BITS:0]   attempts_q, attempts_d;
`endif

  assign fin = {eng.prga_finished, eng.ksa_finished,
                eng.init_finished, eng.load_finished};

  for (genvar g = 0; g < 4; g++) begin : g_hs
    rc4_phase_hs u_hs (
      .clk        (clk),
      .reset      (reset),
      .go         (go[g]),
      .finished   (fin[g]),
      .start      (hs_start[g]),
      .done_pulse (done[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    found_d  = found_q;
    failed_d = failed_q;
    valid_d  = valid_q;
    go       = '0;
`ifdef RC4_STATE_TAP_EN
    attempts_d = attempts_q;
`endif
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d     = S_LOAD;
        go[PH_LOAD] = 1'b1;
        key_d       = KEY_FIRST;
        found_d     = 1'b0;
        failed_d    = 1'b0;
        valid_d     = 1'b0;
`ifdef RC4_STATE_TAP_EN
        attempts_d  = '0;
`endif
      end
      S_LOAD: if (fin[PH_LOAD]) state_d = S_LOAD_REL;
      S_LOAD_REL: if (done[PH_LOAD]) begin
        state_d     = S_INIT;
        go[PH_INIT] = 1'b1;
      end
      S_INIT: if (fin[PH_INIT]) state_d = S_INIT_REL;
      S_INIT_REL: if (done[PH_INIT]) begin
        state_d    = S_KSA;
        go[PH_KSA] = 1'b1;
      end
      S_KSA: if (fin[PH_KSA]) state_d = S_KSA_REL;
      S_KSA_REL: if (done[PH_KSA]) begin
        state_d     = S_PRGA;
        go[PH_PRGA] = 1'b1;
      end
      S_PRGA: if (fin[PH_PRGA]) begin
        state_d = S_PRGA_REL;
        valid_d = eng.msg_valid;
      end
      S_PRGA_REL: if (done[PH_PRGA]) state_d = S_CHECK;
      S_CHECK: begin
`ifdef RC4_STATE_TAP_EN
        attempts_d = attempts_q + (KEY_BITS+1)'(1);
`endif
        if (valid_q) begin
          state_d = S_FOUND;
          found_d = 1'b1;
        end else if (key_q == KEY_LAST) begin
          state_d  = S_FAILED;
          failed_d = 1'b1;
        end else begin
          // ciphertext is unchanged, so the loop re-enters at INIT
          state_d     = S_INIT;
          key_d       = key_q + KEY_BITS'(1);
          go[PH_INIT] = 1'b1;
        end
      end
      S_FOUND, S_FAILED: if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = !(state_d inside {S_IDLE, S_FOUND, S_FAILED});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      key_q    <= KEY_FIRST;
      found_q  <= 1'b0;
      failed_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef RC4_STATE_TAP_EN
      attempts_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      found_q  <= found_d;
      failed_q <= failed_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
`ifdef RC4_STATE_TAP_EN
      attempts_q <= attempts_d;
`endif
    end
  end

  assign eng.load_start = hs_start[PH_LOAD];
  assign eng.init_start = hs_start[PH_INIT];
  assign eng.ksa_start  = hs_start[PH_KSA];
  assign eng.prga_start = hs_start[PH_PRGA];
  assign secret_key     = key_q;
  assign busy           = busy_q;
  assign key_found      = found_q;
  assign key_failed     = failed_q;
`ifdef RC4_STATE_TAP_EN
  assign state_tap      = state_q;
  assign attempts       = attempts_q;
`endif

endmodule

// File: tb/tb_rc4_search_ctrl.sv
// Bench for rc4_search_ctrl: randomized engine models, a queue of expected
// start pulses derived from the key range, and a per-cycle compare process.
module tb_rc4_search_ctrl;

  localparam int KB = 4;
  localparam int KF = 0;
  localparam int KL = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [KB-1:0] secret_key;
  logic          busy;
  logic          key_found;
  logic          key_failed;
`ifdef RC4_STATE_TAP_EN
  logic [3:0]    state_tap;
  logic [KB:0]   attempts;
`endif

  rc4_search_ctrl_if ifc ();

  logic [3:0] fin = '0;
  logic       msgv = 1'b0;
  logic [3:0] starts;

  assign ifc.load_finished = fin[0];
  assign ifc.init_finished = fin[1];
  assign ifc.ksa_finished  = fin[2];
  assign ifc.prga_finished = fin[3];
  assign ifc.msg_valid     = msgv;
  assign starts = {ifc.prga_start, ifc.ksa_start,
                   ifc.init_start, ifc.load_start};

  rc4_search_ctrl #(
    .KEY_BITS  (KB),
    .KEY_FIRST (4'(KF)),
    .KEY_LAST  (4'(KL))
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .eng        (ifc.master),
    .secret_key (secret_key),
    .busy       (busy),
    .key_found  (key_found),
    .key_failed (key_failed)
`ifdef RC4_STATE_TAP_EN
    ,
    .state_tap  (state_tap),
    .attempts   (attempts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph;
    int key;
  } ev_t;

  ev_t q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  lat = 3;
  int  hmin = 0;
  int  hmax = 0;
  int  tgt = -1;
  bit  stray_req = 0;
  bit  stray_on = 0;
  int  last_drop = 0;
  int  last_drop_ph = 0;
  int  exp_load_cyc = 0;
  int  exp_key = 0;
  bit  exp_found = 0;
  int  exp_att = 0;
  int  est[4];
  int  ecnt[4];
  int  ehold[4];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Expected start pulses: one LOAD, then INIT/KSA/PRGA per key tried.
  task automatic plan(input int t);
    q.delete();
    exp_found = 0;
    exp_key   = KF;
    exp_att   = 0;
    q.push_back('{0, KF});
    for (int k = KF; k <= KL; k++) begin
      q.push_back('{1, k});
      q.push_back('{2, k});
      q.push_back('{3, k});
      exp_key = k;
      exp_att = k - KF + 1;
      if (k == t) begin
        exp_found = 1;
        break;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic drop(input int p);
    fin[p]       = 1'b0;
    est[p]       = 0;
    last_drop    = cyc;
    last_drop_ph = p;
    if (p == 0 && stray_req) stray_on = 1;
  endtask

  // Engine models: finished rises lat cycles after start, is held a
  // random number of cycles after start drops, then falls.
  initial begin
    for (int p = 0; p < 4; p++) begin
      est[p]   = 0;
      ecnt[p]  = 0;
      ehold[p] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < 4; p++) begin
        case (est[p])
          0: begin
            if (starts[p]) begin
              est[p]  = 1;
              ecnt[p] = 0;
            end else if (p == 0 && stray_on) begin
              fin[0] = 1'($urandom_range(1, 0));
            end
          end
          1: begin
            if (!starts[p]) begin
              est[p] = 0;
            end else begin
              ecnt[p]++;
              if (ecnt[p] >= lat) begin
                fin[p] = 1'b1;
                est[p] = 2;
                if (p == 3) msgv = (int'(secret_key) == tgt);
              end
            end
          end
          2: begin
            if (!starts[p]) begin
              ehold[p] = int'($urandom_range(hmax, hmin));
              est[p]   = 3;
              if (ehold[p] == 0) drop(p);
            end
          end
          default: begin
            if (ehold[p] > 0) ehold[p]--;
            if (ehold[p] == 0) drop(p);
          end
        endcase
      end
      if (!fin[3]) msgv = 1'($urandom_range(1, 0));
    end
  end

  task automatic on_rise(input int p);
    ev_t e;
    int  ec;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_start: phase %0d rose at key %0d, required none",
               p, secret_key);
    end else begin
      n_chk++;
      e  = q.pop_front();
      ec = (p == 0) ? exp_load_cyc :
           last_drop + 1 + ((p == 1 && last_drop_ph == 3) ? 1 : 0);
      chk("start_phase", p, e.ph);
      chk("start_key", secret_key, e.key);
      chk("start_cycle", cyc, ec);
      chk("busy_in_phase", busy, 1);
      if (p == 0) begin
        chk("flags_clear", {key_found, key_failed}, 0);
`ifdef RC4_STATE_TAP_EN
        chk("attempts_clear", attempts, 0);
`endif
      end
    end
  endtask

  initial begin
    logic [3:0] prev;
    logic [3:0] cur;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = starts;
      if (!reset) begin
        chk("one_start_max", ($countones(cur) <= 1) ? 1 : 0, 1);
        for (int p = 0; p < 4; p++)
          if (cur[p] && !prev[p]) on_rise(p);
      end
      prev = cur;
    end
  end

  task automatic run(input int t, input int l, input int h0, input int h1,
                     input bit str, input bit drop_mid,
                     input bit keep_start, output int rel);
    int c0;
    bit done;
    tgt       = t;
    lat       = l;
    hmin      = h0;
    hmax      = h1;
    stray_req = str;
    plan(t);
    @(posedge clk);
    #1;
    start        = 1'b1;
    c0           = cyc;
    exp_load_cyc = c0 + 1;
    done         = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (drop_mid && cyc == c0 + 3) start = 1'b0;
      if (cyc >= c0 + 2 && (key_found || key_failed)) done = 1;
    end
    chk("run_completes", done, 1);
    rel = cyc - c0;
    if (done) begin
      chk("done_cycle", cyc, last_drop + 2);
      chk("key_found", key_found, exp_found);
      chk("key_failed", key_failed, !exp_found);
      chk("final_key", secret_key, exp_key);
      chk("busy_done", busy, 0);
      chk("queue_drained", q.size(), 0);
`ifdef RC4_STATE_TAP_EN
      chk("attempts_final", attempts, exp_att);
`endif
    end
    stray_req = 0;
    stray_on  = 0;
    fin[0]    = 1'b0;
    if (!keep_start) begin
      start = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    int rel;
    bit hit;
    #1;
    chk("rst_starts", starts, 0);
    chk("rst_key", secret_key, KF);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {key_found, key_failed}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    plan(5);
    chk("model_pulses_key5", q.size(), 19);
    plan(-1);
    chk("model_pulses_none", q.size(), 25);
    chk("model_key_none", exp_key, 7);
    chk("model_att_none", exp_att, 8);
    q.delete();

    // key 0 with 3-cycle engines: five cycles per phase, then CHECK, FOUND
    run(0, 3, 0, 0, 0, 0, 1, rel);
    chk("key0_latency", rel, 22);
    repeat (8) @(negedge clk);
    chk("found_hold", key_found, 1);
    chk("found_hold_starts", starts, 0);
    chk("found_hold_busy", busy, 0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("found_persist", key_found, 1);
    chk("idle_busy", busy, 0);

    run(5, int'($urandom_range(5, 1)), 0, 4, 1, 0, 0, rel);
    run(-1, int'($urandom_range(5, 1)), 0, 2, 1, 0, 0, rel);
    run(2, 3, 4, 4, 0, 0, 0, rel);

    // reset during KSA at key 2
    plan(-1);
    tgt  = -1;
    lat  = 2;
    hmin = 0;
    hmax = 1;
    @(posedge clk);
    #1;
    start        = 1'b1;
    exp_load_cyc = cyc + 1;
    hit          = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (ifc.ksa_start && secret_key == 4'd2) hit = 1;
    end
    chk("reached_ksa_key2", hit, 1);
    #1;
    reset = 1'b1;
    start = 1'b0;
    #1;
    chk("async_rst_starts", starts, 0);
    chk("async_rst_key", secret_key, KF);
    chk("async_rst_busy", busy, 0);
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    run(1, 2, 0, 3, 0, 0, 0, rel);

    for (int n = 0; n < 5; n++)
      run(int'($urandom_range(9, 0)) - 1, int'($urandom_range(5, 1)),
          0, int'($urandom_range(4, 0)), 1'($urandom_range(1, 0)),
          1'($urandom_range(1, 0)), 0, rel);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
